led_event_scheduler: RTL and testbench
======================================

Name: led_event_scheduler

Overview:
- Owns the two RGB indicator LEDs of the chip dispenser and decides what they show.
- By default it passes through the free-running RGB cycle pattern from the existing flasher block.
- Higher-priority events pre-empt that pattern: error (alternating red), chip dispensed (green blink burst) and coin accepted (steady blue).
- Sits between the flasher/dispense controller and the LED pins.

Parameters:
- BLINK_TICKS, 12500000, clk cycles per blink half-period (0.25 s at 50 MHz); must be >= 2.
- DISPENSE_BLINKS, 3, number of green on/off pairs per dispense event; must be >= 1.
- COIN_HOLD_TICKS, 25000000, clk cycles the steady-blue coin indication is held; must be >= 2.
- CNT_W, 27, width of the shared tick counter; must hold max(BLINK_TICKS, COIN_HOLD_TICKS).

Ports:
- clk  input  1  system clock (50 MHz).
- reset  input  1  synchronous, active-high reset.
- flash_rgb1  input  3  {r,g,b} idle pattern for LED1 from the flasher.
- flash_rgb2  input  3  {r,g,b} idle pattern for LED2 from the flasher.
- req_error  input  1  level; high while a fault condition exists.
- req_dispense  input  1  one-cycle pulse per chip dispensed.
- req_coin  input  1  one-cycle pulse per coin accepted.
- led_rgb1  output  3  {r,g,b} drive for LED1, active-high.
- led_rgb2  output  3  {r,g,b} drive for LED2, active-high.
- busy  output  1  high in any state other than IDLE.
- active_src  output  2  0=IDLE, 1=COIN, 2=DISPENSE, 3=ERROR.

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high, sampled on posedge clk.
- Registers: state (IDLE/COIN/DISPENSE/ERROR), tick counter cnt[CNT_W-1:0], phase bit, blink counter, pend_dispense, pend_coin.
- Outputs are combinational decodes of the registers. In IDLE, led_rgb1/led_rgb2 equal flash_rgb1/flash_rgb2 combinationally.
- Reset: state=IDLE, cnt=0, phase=0, blink count=0, both pendings cleared.
  - Resulting outputs: busy=0, active_src=0, LEDs follow the flash inputs.
  - Reset mid-sequence aborts the sequence and discards pendings.
- Pending capture: a req_dispense or req_coin pulse sets its pend flag on that edge, in every state. Repeated pulses coalesce into one pending event.
- Priority at every decision point is ERROR > DISPENSE > COIN > IDLE.
  - Decision points: in IDLE every cycle, and at completion of COIN/DISPENSE.
  - A request (pulse or pend) sampled at edge k takes effect at edge k. The new state and pattern are visible from edge k onward, so latency is 0 cycles from the sampling edge.
- Entering any state loads cnt=0, phase=0, blink count=0.
- ERROR:
  - Entered from any state the edge req_error is sampled high; this pre-empts COIN/DISPENSE immediately.
  - phase=0: led_rgb1=3'b100, led_rgb2=0. phase=1: the reverse.
  - phase toggles and cnt clears when cnt==BLINK_TICKS-1.
  - Exits at the first edge req_error is sampled low, to the next-priority pending state or IDLE.
  - A pre-empted COIN/DISPENSE keeps its pend flag set and restarts from the beginning.
- DISPENSE:
  - phase=0: both LEDs 3'b010. phase=1: both off. Each phase lasts BLINK_TICKS cycles.
  - After DISPENSE_BLINKS on/off pairs, i.e. exactly 2*BLINK_TICKS*DISPENSE_BLINKS cycles, pend_dispense clears and the scheduler decides the next state.
  - A pulse arriving in the completion cycle stays pending and is replayed.
- COIN:
  - Both LEDs 3'b001 for exactly COIN_HOLD_TICKS cycles, then pend_coin clears and the scheduler decides the next state.
  - COIN is not pre-empted by DISPENSE; the dispense request waits.
- Simultaneous dispense+coin in IDLE: DISPENSE runs first, then COIN.
- Counter never exceeds its terminal value, so no wrap-around occurs.

Test Plan:
All scenarios use BLINK_TICKS=4, DISPENSE_BLINKS=2, COIN_HOLD_TICKS=6.
- Reset held 3 cycles with flash_rgb1=3'b100, flash_rgb2=3'b001 -> led_rgb1=100, led_rgb2=001, busy=0, active_src=0 in every cycle after reset.
- req_dispense pulse at edge k -> active_src=2 from k. Both LEDs 010 for cycles k..k+3, off for k+4..k+7, 010 for k+8..k+11, off for k+12..k+15. IDLE at k+16.
- req_coin pulse -> both LEDs 001 for 6 cycles, then IDLE. A second req_coin during the hold -> exactly one replay of 6 cycles, then IDLE.
- req_error raised 5 cycles into DISPENSE, held 10 cycles -> ERROR at the same edge. LED1 red for 4 cycles, then LED2 red for 4, alternating. On release, DISPENSE restarts with its full 16-cycle sequence.
- req_dispense and req_coin in the same cycle -> 16-cycle DISPENSE, then immediately 6-cycle COIN, then IDLE. busy stays high for all 22 cycles.
- reset asserted mid-COIN with pend_dispense set -> IDLE next edge, no replay, busy=0.

Source files
------------

// File: rtl/led_event_scheduler.sv
// led_event_scheduler
//   Owns the two RGB indicator LEDs of the chip dispenser. In IDLE the
//   free-running flasher pattern passes straight through; error, dispense
//   and coin events pre-empt it with priority ERROR > DISPENSE > COIN > IDLE.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   flash_rgb1   {r,g,b} idle pattern for LED1
//   flash_rgb2   {r,g,b} idle pattern for LED2
//   req_error    level, high while a fault exists
//   req_dispense one-cycle pulse per chip dispensed
//   req_coin     one-cycle pulse per coin accepted
//   led_rgb1     {r,g,b} drive for LED1, active-high
//   led_rgb2     {r,g,b} drive for LED2, active-high
//   busy         high in any state other than IDLE
//   active_src   0=IDLE, 1=COIN, 2=DISPENSE, 3=ERROR
module led_event_scheduler #(
  parameter int unsigned BLINK_TICKS     = 12500000,
  parameter int unsigned DISPENSE_BLINKS = 3,
  parameter int unsigned COIN_HOLD_TICKS = 25000000,
  parameter int unsigned CNT_W           = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] flash_rgb1,
  input  logic [2:0] flash_rgb2,
  input  logic       req_error,
  input  logic       req_dispense,
  input  logic       req_coin,
  output logic [2:0] led_rgb1,
  output logic [2:0] led_rgb2,
  output logic       busy,
  output logic [1:0] active_src
);

  localparam int unsigned BLK_W = (DISPENSE_BLINKS > 1) ? $clog2(DISPENSE_BLINKS) : 1;

  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_TICKS - 1);
  localparam logic [CNT_W-1:0] COIN_LAST  = CNT_W'(COIN_HOLD_TICKS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST   = BLK_W'(DISPENSE_BLINKS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COIN     = 2'd1,
    DISPENSE = 2'd2,
    ERROR    = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             phase, phase_n;
  logic [BLK_W-1:0] blk, blk_n;
  logic             pend_d, pend_d_n;
  logic             pend_c, pend_c_n;
  logic             decide;
  logic             load;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      phase  <= 1'b0;
      blk    <= '0;
      pend_d <= 1'b0;
      pend_c <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      phase  <= phase_n;
      blk    <= blk_n;
      pend_d <= pend_d_n;
      pend_c <= pend_c_n;
    end
  end

  // A pend flag is consumed when its state is (re)entered, so it only holds
  // requests that still need a future run: pulses arriving during a run cause
  // exactly one replay, and an ERROR pre-emption re-arms the interrupted one.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt + 1'b1;
    phase_n  = phase;
    blk_n    = blk;
    pend_d_n = pend_d | req_dispense;
    pend_c_n = pend_c | req_coin;
    decide   = 1'b0;
    load     = 1'b0;

    case (state)
      IDLE: begin
        cnt_n  = '0;
        decide = 1'b1;
      end
      COIN: begin
        if (cnt == COIN_LAST) decide = 1'b1;
      end
      DISPENSE: begin
        if (cnt == BLINK_LAST) begin
          cnt_n   = '0;
          phase_n = ~phase;
          if (phase) begin
            if (blk == BLK_LAST) decide = 1'b1;
            else                 blk_n  = blk + 1'b1;
          end
        end
      end
      ERROR: begin
        if (cnt == BLINK_LAST) begin
          cnt_n   = '0;
          phase_n = ~phase;
        end
        decide = 1'b1;
      end
      default: ;
    endcase

    if (req_error) begin
      if (state != ERROR) begin
        state_n = ERROR;
        load    = 1'b1;
      end
      if (state == DISPENSE) pend_d_n = 1'b1;
      if (state == COIN)     pend_c_n = 1'b1;
    end else if (decide) begin
      load = 1'b1;
      if (pend_d_n) begin
        state_n  = DISPENSE;
        pend_d_n = 1'b0;
      end else if (pend_c_n) begin
        state_n  = COIN;
        pend_c_n = 1'b0;
      end else begin
        state_n  = IDLE;
      end
    end

    if (load) begin
      cnt_n   = '0;
      phase_n = 1'b0;
      blk_n   = '0;
    end
  end

  always_comb begin
    led_rgb1   = flash_rgb1;
    led_rgb2   = flash_rgb2;
    busy       = (state != IDLE);
    active_src = state;
    case (state)
      COIN: begin
        led_rgb1 = 3'b001;
        led_rgb2 = 3'b001;
      end
      DISPENSE: begin
        led_rgb1 = phase ? 3'b000 : 3'b010;
        led_rgb2 = phase ? 3'b000 : 3'b010;
      end
      ERROR: begin
        led_rgb1 = phase ? 3'b000 : 3'b100;
        led_rgb2 = phase ? 3'b100 : 3'b000;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_led_event_scheduler.sv
// Testbench for led_event_scheduler with BLINK_TICKS=4, DISPENSE_BLINKS=2,
// COIN_HOLD_TICKS=6. Each driven cycle pushes the expected
// {led_rgb1, led_rgb2, busy, active_src} onto a queue; the value is popped
// and compared once the DUT has produced that cycle's output.
module tb_led_event_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] flash_rgb1 = 3'b100;
  logic [2:0] flash_rgb2 = 3'b001;
  logic       req_error = 1'b0;
  logic       req_dispense = 1'b0;
  logic       req_coin = 1'b0;
  logic [2:0] led_rgb1;
  logic [2:0] led_rgb2;
  logic       busy;
  logic [1:0] active_src;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [8:0]  sb[$];

  led_event_scheduler #(
    .BLINK_TICKS(4),
    .DISPENSE_BLINKS(2),
    .COIN_HOLD_TICKS(6),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flash_rgb1(flash_rgb1),
    .flash_rgb2(flash_rgb2),
    .req_error(req_error),
    .req_dispense(req_dispense),
    .req_coin(req_coin),
    .led_rgb1(led_rgb1),
    .led_rgb2(led_rgb2),
    .busy(busy),
    .active_src(active_src)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] G = 3'b010;
  localparam logic [2:0] B = 3'b001;
  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] O = 3'b000;

  function automatic logic [8:0] ev(input logic [2:0] l1, input logic [2:0] l2,
                                    input logic [1:0] src);
    return {l1, l2, (src != 2'd0), src};
  endfunction

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got led1=%b led2=%b busy=%b src=%0d, expected led1=%b led2=%b busy=%b src=%0d",
               tag, got[8:6], got[5:3], got[2], got[1:0],
               exp[8:6], exp[5:3], exp[2], exp[1:0]);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, then compare after the
  // sampling edge once outputs have settled.
  task automatic cyc(input string tag, input logic r, input logic e, input logic d,
                     input logic c, input logic [8:0] exp);
    logic [8:0] want;
    reset        = r;
    req_error    = e;
    req_dispense = d;
    req_coin     = c;
    sb.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    want = sb.pop_front();
    check(tag, {led_rgb1, led_rgb2, busy, active_src}, want);
  endtask

  task automatic idle(input string tag, input int unsigned n);
    for (int unsigned i = 0; i < n; i++)
      cyc(tag, 1'b0, 1'b0, 1'b0, 1'b0, ev(flash_rgb1, flash_rgb2, 2'd0));
  endtask

  // Full 16-cycle dispense pattern; the first cycle optionally carries pulses.
  task automatic dispense_seq(input string tag, input logic d0, input logic c0);
    for (int unsigned i = 0; i < 16; i++)
      cyc(tag, 1'b0, 1'b0, (i == 0) ? d0 : 1'b0, (i == 0) ? c0 : 1'b0,
          ((i / 4) % 2 == 0) ? ev(G, G, 2'd2) : ev(O, O, 2'd2));
  endtask

  initial begin
    // reset with flash passthrough
    for (int unsigned i = 0; i < 3; i++)
      cyc("reset", 1'b1, 1'b0, 1'b0, 1'b0, ev(3'b100, 3'b001, 2'd0));
    idle("idle_after_reset", 2);
    flash_rgb1 = 3'b011;
    flash_rgb2 = 3'b110;
    idle("idle_pass", 2);

    // single dispense burst
    dispense_seq("dispense", 1'b1, 1'b0);
    idle("dispense_done", 2);

    // single coin hold
    cyc("coin", 1'b0, 1'b0, 1'b0, 1'b1, ev(B, B, 2'd1));
    for (int unsigned i = 0; i < 5; i++)
      cyc("coin", 1'b0, 1'b0, 1'b0, 1'b0, ev(B, B, 2'd1));
    idle("coin_done", 2);

    // coin with a second pulse during the hold: one replay
    cyc("coin2", 1'b0, 1'b0, 1'b0, 1'b1, ev(B, B, 2'd1));
    for (int unsigned i = 1; i < 12; i++)
      cyc("coin2", 1'b0, 1'b0, 1'b0, (i == 2), ev(B, B, 2'd1));
    idle("coin2_done", 2);

    // error pre-empts dispense five cycles in, then dispense restarts
    cyc("pre_err", 1'b0, 1'b0, 1'b1, 1'b0, ev(G, G, 2'd2));
    for (int unsigned i = 1; i < 5; i++)
      cyc("pre_err", 1'b0, 1'b0, 1'b0, 1'b0, (i < 4) ? ev(G, G, 2'd2) : ev(O, O, 2'd2));
    for (int unsigned i = 0; i < 10; i++)
      cyc("error", 1'b0, 1'b1, 1'b0, 1'b0,
          ((i / 4) % 2 == 0) ? ev(R, O, 2'd3) : ev(O, R, 2'd3));
    dispense_seq("restart", 1'b0, 1'b0);
    idle("restart_done", 2);

    // simultaneous dispense and coin: dispense, then coin, then idle
    dispense_seq("both_d", 1'b1, 1'b1);
    for (int unsigned i = 0; i < 6; i++)
      cyc("both_c", 1'b0, 1'b0, 1'b0, 1'b0, ev(B, B, 2'd1));
    idle("both_done", 2);

    // reset mid-coin with a dispense pending discards everything
    cyc("mid_coin", 1'b0, 1'b0, 1'b0, 1'b1, ev(B, B, 2'd1));
    cyc("mid_coin", 1'b0, 1'b0, 1'b0, 1'b0, ev(B, B, 2'd1));
    cyc("mid_coin", 1'b0, 1'b0, 1'b1, 1'b0, ev(B, B, 2'd1));
    cyc("mid_coin", 1'b0, 1'b0, 1'b0, 1'b0, ev(B, B, 2'd1));
    cyc("mid_reset", 1'b1, 1'b0, 1'b0, 1'b0, ev(flash_rgb1, flash_rgb2, 2'd0));
    idle("no_replay", 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
